// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI master data path.
package spi_pkg;

  localparam int SPI_DW = 8;
  localparam int SPI_IW = 3;

  // Effective edge-selection mode: 0 for SPI modes 0/3, 1 for modes 1/2.
  function automatic logic spi_mode_x(input logic cpol, input logic cpha);
    return cpol ^ cpha;
  endfunction

  // Bit pointer start position: MSB for MSB-first, LSB for LSB-first.
  function automatic logic [SPI_IW-1:0] spi_start_idx(input logic lsbfe);
    return lsbfe ? 3'd0 : 3'd7;
  endfunction

endpackage

// File: rtl/spi_shift_register_if.sv
// Control, edge-flag and data signals between the SPI control logic and the
// shift register data path.
interface spi_shift_register_if;
  import spi_pkg::*;

  logic              ss;
  logic              send_data;
  logic              receive_data;
  logic              lsbfe;
  logic              cpha;
  logic              cpol;
  logic              flag_low;
  logic              flag_high;
  logic              flags_low;
  logic              flags_high;
  logic [SPI_DW-1:0] data_mosi;
  logic              miso;
  logic              mosi;
  logic [SPI_DW-1:0] data_miso;

  modport master (
    output ss, send_data, receive_data, lsbfe, cpha, cpol,
    output flag_low, flag_high, flags_low, flags_high,
    output data_mosi, miso,
    input  mosi, data_miso
  );

  modport slave (
    input  ss, send_data, receive_data, lsbfe, cpha, cpol,
    input  flag_low, flag_high, flags_low, flags_high,
    input  data_mosi, miso,
    output mosi, data_miso
  );

endinterface

// File: rtl/spi_bit_ptr.sv
// 3-bit bit pointer: reloads to a start value, otherwise steps up or down
// (modulo 8) on advance. Reload has priority over advance.
module spi_bit_ptr
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              advance,
  input  logic              up,
  input  logic [SPI_IW-1:0] start,
  output logic [SPI_IW-1:0] idx
);

  logic [SPI_IW-1:0] idx_next;

  // Next pointer value: reload, step in the selected direction, or hold.
  always_comb begin
    idx_next = idx;
    if (reload) begin
      idx_next = start;
    end else if (advance) begin
      if (up) begin
        idx_next = idx + 3'd1;
      end else begin
        idx_next = idx - 3'd1;
      end
    end else begin
      idx_next = idx;
    end
  end

  // Pointer register; resets to the MSB position regardless of bit order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 3'd7;
    end else begin
      idx <= idx_next;
    end
  end

endmodule

// File: rtl/spi_shift_register.sv
// SPI master data path: serialises the transmit byte onto mosi and assembles
// received miso bits into a byte, with edge choice and bit order taken from
// the SPI mode inputs.
module spi_shift_register
  import spi_pkg::*;
(
  input  logic                 PCLK,
  input  logic                 PRESET,
  spi_shift_register_if.slave  bus
);

  logic              mode_x;
  logic              tx_edge;
  logic              rx_edge;
  logic              reload;
  logic              tx_shift;
  logic              rx_shift;
  logic [SPI_IW-1:0] start_idx;
  logic [SPI_IW-1:0] tx_idx;
  logic [SPI_IW-1:0] rx_idx;
  logic [SPI_DW-1:0] tx_reg;
  logic [SPI_DW-1:0] rx_reg;
  logic              mosi_q;
  logic [SPI_DW-1:0] data_miso_q;

  // Edge selection and shift qualification. A load in the same cycle as a
  // transmit edge wins, so that edge neither shifts nor advances the pointer.
  always_comb begin
    mode_x    = spi_mode_x(bus.cpol, bus.cpha);
    start_idx = spi_start_idx(bus.lsbfe);
    if (mode_x) begin
      tx_edge = bus.flag_high;
      rx_edge = bus.flags_low;
    end else begin
      tx_edge = bus.flag_low;
      rx_edge = bus.flags_high;
    end
    reload   = bus.ss | bus.send_data;
    tx_shift = tx_edge & ~bus.ss & ~bus.send_data;
    rx_shift = rx_edge & ~bus.ss;
  end

  spi_bit_ptr u_tx_ptr (
    .clk     (PCLK),
    .rst     (PRESET),
    .reload  (reload),
    .advance (tx_shift),
    .up      (bus.lsbfe),
    .start   (start_idx),
    .idx     (tx_idx)
  );

  spi_bit_ptr u_rx_ptr (
    .clk     (PCLK),
    .rst     (PRESET),
    .reload  (reload),
    .advance (rx_shift),
    .up      (bus.lsbfe),
    .start   (start_idx),
    .idx     (rx_idx)
  );

  // Transmit byte: captured on the load strobe, independent of slave select.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_reg <= 8'h00;
    end else if (bus.send_data) begin
      tx_reg <= bus.data_mosi;
    end else begin
      tx_reg <= tx_reg;
    end
  end

  // Serial output: drives the pointed-to bit on each qualified transmit edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      mosi_q <= 1'b0;
    end else if (tx_shift) begin
      mosi_q <= tx_reg[tx_idx];
    end else begin
      mosi_q <= mosi_q;
    end
  end

  // Receive assembly: stores miso at the pointed-to bit on each rx edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_reg <= 8'h00;
    end else if (rx_shift) begin
      rx_reg[rx_idx] <= bus.miso;
    end else begin
      rx_reg <= rx_reg;
    end
  end

  // Received byte output: takes the pre-update assembly register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      data_miso_q <= 8'h00;
    end else if (bus.receive_data) begin
      data_miso_q <= rx_reg;
    end else begin
      data_miso_q <= data_miso_q;
    end
  end

  assign bus.mosi      = mosi_q;
  assign bus.data_miso = data_miso_q;

endmodule

// File: tb/tb_spi_shift_register.sv
// Self-checking bench for spi_shift_register: directed scenarios followed by
// randomized traffic, all compared against a byte-level behavioural model.
module tb_spi_shift_register;

  logic PCLK;
  logic PRESET;
  int   total;
  int   bad;

  // Reference model state: bytes plus edge counters since the last reload.
  logic [7:0] m_tx;
  logic [7:0] m_rx;
  logic [7:0] m_dm;
  logic       m_mosi;
  int         m_txc;
  int         m_rxc;
  logic       m_lsb;

  spi_shift_register_if bus ();

  spi_shift_register dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_mosi"}, {7'd0, bus.mosi}, {7'd0, m_mosi});
    chk({tag, "_dmiso"}, bus.data_miso, m_dm);
  endtask

  task automatic model_reset();
    m_tx = 8'h00; m_rx = 8'h00; m_dm = 8'h00; m_mosi = 1'b0;
    m_txc = 0; m_rxc = 0; m_lsb = 1'b0;
  endtask

  // One PCLK cycle of stimulus (called at a falling edge); pulses last one
  // cycle. The model applies the behavioural rules for the same cycle.
  task automatic step(input logic fl, input logic fh, input logic fsl, input logic fsh,
                      input logic snd, input logic rcv, input logic mi, input logic [7:0] d);
    logic mx, txe, rxe;
    int   bit_pos;
    bus.flag_low = fl; bus.flag_high = fh; bus.flags_low = fsl; bus.flags_high = fsh;
    bus.send_data = snd; bus.receive_data = rcv; bus.miso = mi;
    if (snd) bus.data_mosi = d;
    mx  = bus.cpol ^ bus.cpha;
    txe = mx ? fh : fl;
    rxe = mx ? fsl : fsh;
    if (rcv) m_dm = m_rx;
    if (!bus.ss && rxe) begin
      bit_pos = m_lsb ? m_rxc : 7 - m_rxc;
      m_rx[bit_pos] = mi;
    end
    if (snd) begin
      m_tx = d;
    end else if (!bus.ss && txe) begin
      bit_pos = m_lsb ? m_txc : 7 - m_txc;
      m_mosi = m_tx[bit_pos];
      m_txc = (m_txc + 1) % 8;
    end
    if (bus.ss || snd) begin
      m_txc = 0; m_rxc = 0; m_lsb = bus.lsbfe;
    end else if (rxe) begin
      m_rxc = (m_rxc + 1) % 8;
    end
    @(negedge PCLK);
    bus.flag_low = 1'b0; bus.flag_high = 1'b0; bus.flags_low = 1'b0; bus.flags_high = 1'b0;
    bus.send_data = 1'b0; bus.receive_data = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] hold_dm;
    logic       hold_mosi;
    total = 0;
    bad   = 0;
    bus.ss = 1'b1; bus.send_data = 1'b0; bus.receive_data = 1'b0;
    bus.lsbfe = 1'b0; bus.cpha = 1'b0; bus.cpol = 1'b0;
    bus.flag_low = 1'b0; bus.flag_high = 1'b0; bus.flags_low = 1'b0; bus.flags_high = 1'b0;
    bus.data_mosi = 8'h00; bus.miso = 1'b0;
    PRESET = 1'b1;
    model_reset();
    #3;
    chk("reset_mosi", {7'd0, bus.mosi}, 8'h00);
    chk("reset_dmiso", bus.data_miso, 8'h00);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Mode 0, MSB first: transmit 0xAA, receive 0xCB.
    bus.ss = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
    pat = 8'b1010_1010;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("m0_tx_bit%0d", i), {7'd0, bus.mosi}, {7'd0, pat[7-i]});
    end
    pat = 8'b1100_1011;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pat[7-i], 8'h00);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("m0_rx_byte", bus.data_miso, 8'hCB);

    // Mode 1, LSB first: transmit 0x01, receive 0x01; off-mode flags ignored.
    bus.ss = 1'b1;
    bus.cpha = 1'b1; bus.lsbfe = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.ss = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("m1_tx_bit%0d", i), {7'd0, bus.mosi}, (i == 0) ? 8'h01 : 8'h00);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("m1_flag_low_ignored%0d", i), {7'd0, bus.mosi}, (i == 0) ? 8'h01 : 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (i == 0), 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("m1_rx_byte", bus.data_miso, 8'h01);

    // Slave deselected: edges ignored, contents held.
    bus.ss = 1'b1;
    hold_mosi = bus.mosi;
    hold_dm   = bus.data_miso;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    end
    chk("ss_hold_mosi", {7'd0, bus.mosi}, {7'd0, hold_mosi});
    chk("ss_hold_dmiso", bus.data_miso, hold_dm);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("ss_hold_rxreg", bus.data_miso, 8'h01);
    bus.cpha = 1'b0; bus.lsbfe = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
    bus.ss = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ss_release_bit7", {7'd0, bus.mosi}, 8'h01);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ss_release_bit6", {7'd0, bus.mosi}, 8'h00);

    // Load and transmit edge together: no shift, pointer restarts at bit 7.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
    chk("load_vs_edge_noshift", {7'd0, bus.mosi}, 8'h00);
    pat = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("load_vs_edge_bit%0d", 7 - i), {7'd0, bus.mosi}, {7'd0, pat[7-i]});
    end

    // Receive latch together with an rx edge: old byte out, bit still stored.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    chk("recv_vs_edge_old", bus.data_miso, 8'hA1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("recv_vs_edge_new", bus.data_miso, 8'hB1);

    // Mode 3 wrap-around: the 9th edge repeats bit 7.
    bus.ss = 1'b1; bus.cpol = 1'b1; bus.cpha = 1'b1; bus.lsbfe = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.ss = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("m3_wrap_edge%0d", i + 1), {7'd0, bus.mosi},
          (i == 0 || i == 8) ? 8'h01 : 8'h00);
    end

    // Asynchronous reset mid-byte, observed between clock edges.
    check_all("pre_reset");
    @(posedge PCLK);
    #2;
    PRESET = 1'b1;
    #1;
    chk("async_reset_mosi", {7'd0, bus.mosi}, 8'h00);
    chk("async_reset_dmiso", bus.data_miso, 8'h00);
    model_reset();
    bus.ss = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;

    // Randomized traffic against the model.
    for (int b = 0; b < 40; b++) begin
      bus.ss = 1'b1;
      bus.cpol  = 1'($urandom_range(1, 0));
      bus.cpha  = 1'($urandom_range(1, 0));
      bus.lsbfe = 1'($urandom_range(1, 0));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check_all("rnd_idle");
      bus.ss = 1'b0;
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0, 1'b0,
           1'b1, 1'b0, 1'b0, 8'($urandom));
      check_all("rnd_load");
      for (int c = 0; c < 20; c++) begin
        step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             1'b0, ($urandom_range(9, 0) == 0), 1'($urandom_range(1, 0)), 8'h00);
        check_all("rnd_shift");
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check_all("rnd_recv");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
